// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : controller_sequencer
// Description : Six-state ring-counter sequencer with combinational control decode and sticky halt.
// Revision    : 1.0
// ============================================================================
module controller_sequencer (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic [3:0] opcode,
  output logic       C_P,
  output logic       E_P,
  output logic       L_M,
  output logic       C_E,
  output logic       L_I,
  output logic       E_I,
  output logic       L_A,
  output logic       E_A,
  output logic       S_U,
  output logic       E_U,
  output logic       L_B,
  output logic       L_O,
  output logic       HLT,
  output logic [5:0] T
);

  localparam logic [3:0] c_OP_LDA = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_OUT = 4'b1110;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } ring_t;

  ring_t r_ring;
  logic  r_halt;
  logic  w_halt_fire;

  assign w_halt_fire = (r_ring == ST_T4) && (opcode == c_OP_HLT);

  // Halting freezes the ring at T4; only reset releases it.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      r_ring <= ST_T1;
      r_halt <= 1'b0;
    end else if (!r_halt) begin
      if (w_halt_fire) begin
        r_halt <= 1'b1;
      end else begin
        case (r_ring)
          ST_T1:   r_ring <= ST_T2;
          ST_T2:   r_ring <= ST_T3;
          ST_T3:   r_ring <= ST_T4;
          ST_T4:   r_ring <= ST_T5;
          ST_T5:   r_ring <= ST_T6;
          default: r_ring <= ST_T1;
        endcase
      end
    end
  end

  assign T = r_ring;

  always_comb begin
    C_P = 1'b0;
    E_P = 1'b0;
    L_M = 1'b0;
    C_E = 1'b0;
    L_I = 1'b0;
    E_I = 1'b0;
    L_A = 1'b0;
    E_A = 1'b0;
    S_U = 1'b0;
    E_U = 1'b0;
    L_B = 1'b0;
    L_O = 1'b0;
    HLT = 1'b0;
    if (CLR_n) begin
      if (r_halt) begin
        HLT = 1'b1;
      end else begin
        case (r_ring)
          ST_T1: begin
            E_P = 1'b1;
            L_M = 1'b1;
          end
          ST_T2: C_P = 1'b1;
          ST_T3: begin
            C_E = 1'b1;
            L_I = 1'b1;
          end
          ST_T4: begin
            case (opcode)
              c_OP_LDA, c_OP_ADD, c_OP_SUB: begin
                E_I = 1'b1;
                L_M = 1'b1;
              end
              c_OP_OUT: begin
                E_A = 1'b1;
                L_O = 1'b1;
              end
              c_OP_HLT: HLT = 1'b1;
              default: ;
            endcase
          end
          ST_T5: begin
            if (opcode == c_OP_LDA) begin
              C_E = 1'b1;
              L_A = 1'b1;
            end else if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
              C_E = 1'b1;
              L_B = 1'b1;
            end
          end
          ST_T6: begin
            if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
              E_U = 1'b1;
              L_A = 1'b1;
              S_U = (opcode == c_OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 CLK  input  1  system clock; all state changes on the rising edge.
REQ-002 CLR_n  input  1  reset, synchronous, active-low; sampled on the CLK rising edge.
REQ-003 opcode  input  4  instruction register upper nibble; valid from T4 onward.
REQ-004 C_P  output  1  program counter increment.
REQ-005 E_P  output  1  program counter drives bus.
REQ-006 L_M  output  1  MAR load from bus.
REQ-007 C_E  output  1  RAM drives bus.
REQ-008 L_I  output  1  instruction register load from bus.
REQ-009 E_I  output  1  instruction register lower nibble drives bus.
REQ-010 L_A  output  1  accumulator load from bus.
REQ-011 E_A  output  1  accumulator drives bus.
REQ-012 S_U  output  1  adder/subtractor mode: 1 = subtract, 0 = add.
REQ-013 E_U  output  1  adder/subtractor result drives bus.
REQ-014 L_B  output  1  B register load from bus.
REQ-015 L_O  output  1  output register load from bus.
REQ-016 HLT  output  1  halt flag; the clock gate elsewhere uses it to stop the machine.
REQ-017 T  output  6  one-hot ring-counter state, bit0 = T1 through bit5 = T6.
REQ-018 All control outputs SHALL be active-high.

Function
REQ-019 Ring counter SHALL advance T1->T2->...->T6->T1, one state per CLK, unless halted.
REQ-020 Control outputs SHALL be a combinational decode of T and opcode, with no added latency.
REQ-021 Any control output not listed for a state SHALL be 0 in that state.
REQ-022 Fetch, all opcodes:
- T1: E_P, L_M.
- T2: C_P.
- T3: C_E, L_I.
REQ-023 LDA (0000):
- T4: E_I, L_M.
- T5: C_E, L_A.
- T6: none.
REQ-024 ADD (0001):
- T4: E_I, L_M.
- T5: C_E, L_B.
- T6: E_U, L_A; S_U=0.
REQ-025 SUB (0010): identical to ADD except S_U=1 in T6.
REQ-026 OUT (1110):
- T4: E_A, L_O.
- T5, T6: none.
REQ-027 HLT (1111): at T4, HLT SHALL assert combinationally.
REQ-028 On the HLT rising edge, a sticky halt register SHALL set and the ring counter SHALL freeze at T4.
REQ-029 While halted: HLT SHALL stay 1 and all other control outputs SHALL be 0.
REQ-030 Halt SHALL be cleared only by reset.
REQ-031 Any other opcode SHALL execute as a NOP in T4-T6 (fetch still performed).
REQ-032 Bus exclusivity: at most one of E_P, C_E, E_I, E_A, E_U SHALL be 1 in any cycle.
REQ-033 Opcode changes during T1-T3 SHALL NOT affect outputs.

Reset
REQ-034 CLR_n=0 at a rising edge SHALL set T=000001 and clear the halt register, from any state, including mid-instruction and while halted.
REQ-035 While CLR_n=0, all control outputs and HLT SHALL be forced to 0 combinationally.
REQ-036 Execution SHALL begin at T1 on the first rising edge with CLR_n=1.

Verification
REQ-037 Reset then 6 clocks, opcode=0000: T sequence 01,02,04,08,10,20 (hex), then 01; outputs per REQ-022/023 each cycle.
REQ-038 opcode=0010: in T6, S_U=1, E_U=1, L_A=1, all others 0; with opcode=0001, same except S_U=0.
REQ-039 opcode=1111: HLT=1 at T4; after 10 further clocks T=08, HLT=1, all other controls 0; CLR_n=0 for one edge -> T=01, HLT=0.
REQ-040 opcode=0001, CLR_n pulsed low during T5: next T=01, outputs 0 while CLR_n=0, fetch restarts.
REQ-041 opcode=0111 (undefined): T4-T6 all controls 0, cycle returns to T1.
REQ-042 Random opcode stream, 1000 cycles: a checker confirms REQ-032 every cycle and one-hot T always.
